mem_accum_ctrl: RTL and testbench

//  Parametrised successor of the fixed sum-and-store datapath: reads Count consecutive words

---
 rtl/mem_accum_ctrl_if.sv | 32 +++
 rtl/mem_accum_ctrl.sv | 119 +++++++++++
 tb/tb_mem_accum_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_accum_ctrl_if.sv
// Memory-side and control-side signals of the sum-and-store controller.
// The controller takes the slave view; the bench (memory + requester) takes the master view.
interface mem_accum_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    // Start is a request that takes effect only on a cycle where Ready=1;
    // it is never queued, and a Start held high is taken at the next Ready cycle.
    logic                  Start;
    logic [ADDR_WIDTH-1:0] BaseAddr;
    logic [ADDR_WIDTH:0]   Count;
    logic [ADDR_WIDTH-1:0] DestAddr;
    logic                  Mode;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  Ready;
    logic                  Done;
    logic                  Overflow;
    logic [ADDR_WIDTH-1:0] Address;
    logic                  ReadEnable;
    logic                  WriteEnable;
    logic [DATA_WIDTH-1:0] DataIN;

    modport slave (
        input  Start, BaseAddr, Count, DestAddr, Mode, DataOut,
        output Ready, Done, Overflow, Address, ReadEnable, WriteEnable, DataIN
    );

    modport master (
        output Start, BaseAddr, Count, DestAddr, Mode, DataOut,
        input  Ready, Done, Overflow, Address, ReadEnable, WriteEnable, DataIN
    );
endinterface

// File: rtl/mem_accum_ctrl.sv
// Reads Count words from a synchronous memory starting at BaseAddr, sums them
// (wrap or saturate) and writes the sum to DestAddr, with a Start/Ready/Done handshake.
module mem_accum_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_accum_ctrl_if.slave     bus,
    output logic [2:0]          dbg_state_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH:0]   sum;

    assign rd_addr = base_q + idx_q[ADDR_WIDTH-1:0];
    assign sum     = {1'b0, acc_q} + {1'b0, bus.DataOut};

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        dest_d  = dest_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;

        // rd_q marks that memory data for last cycle's read is on DataOut now
        if (rd_q) begin
            acc_d = (mode_q && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
            ovf_d = ovf_q | sum[DATA_WIDTH];
        end

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    base_d  = bus.BaseAddr;
                    count_d = bus.Count;
                    dest_d  = bus.DestAddr;
                    mode_d  = bus.Mode;
                    acc_d   = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.Count == '0) ? WRITE : FETCH;
                end
            end
            FETCH: begin
                rd_d   = 1'b1;
                addr_d = rd_addr;
                if (idx_q == count_q - CNT_ONE) state_d = DRAIN;
                else                            idx_d   = idx_q + CNT_ONE;
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                addr_d  = dest_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            dest_q  <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    // Address follows the active strobe and otherwise holds the last strobed value
    assign bus.Address     = (state_q == FETCH) ? rd_addr :
                             (state_q == WRITE) ? dest_q  : addr_q;
    assign bus.ReadEnable  = (state_q == FETCH);
    assign bus.WriteEnable = (state_q == WRITE);
    assign bus.DataIN      = acc_q;
    assign bus.Ready       = (state_q == IDLE);
    assign bus.Done        = (state_q == DONE);
    assign bus.Overflow    = ovf_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_accum_ctrl.sv
// Directed bench: behavioural synchronous memory plus a linear sequence of runs
// with hand-computed sums, cycle positions and flags.
module tb_mem_accum_ctrl;
    logic        Clock;
    logic        Reset;
    logic [2:0]  dbg_state;
    logic [15:0] mem [64];
    logic [15:0] snap [64];
    int          tests;
    int          fails;

    mem_accum_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

    mem_accum_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bus.ReadEnable)  bus.DataOut <= mem[bus.Address];
        if (bus.WriteEnable) mem[bus.Address] <= bus.DataIN;
    end

    always @(negedge Clock) begin
        if (bus.ReadEnable && bus.WriteEnable) begin
            fails++;
            $error("FAIL strobe_excl: observed re=1 we=1 expected not both");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.Ready), 32'd1);
        check({tag, "_done"},  32'(bus.Done), 32'd0);
        check({tag, "_ovf"},   32'(bus.Overflow), 32'd0);
        check({tag, "_re"},    32'(bus.ReadEnable), 32'd0);
        check({tag, "_we"},    32'(bus.WriteEnable), 32'd0);
        check({tag, "_addr"},  32'(bus.Address), 32'd0);
        check({tag, "_din"},   32'(bus.DataIN), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // One full run; poke>0 raises Start during that cycle number after accept.
    task automatic run(input string tag, input logic [5:0] base, input logic [6:0] cnt,
                       input logic [5:0] dest, input logic mode, input logic [15:0] exp_sum,
                       input logic exp_ovf, input int poke);
        int reads, wcyc, dcyc, rcyc, dpulses, exp_w;
        logic [5:0]  waddr;
        logic [15:0] wdata;
        reads = 0; wcyc = -1; dcyc = -1; rcyc = -1; dpulses = 0;
        waddr = '0; wdata = '0;
        @(negedge Clock);
        bus.BaseAddr = base;
        bus.Count    = cnt;
        bus.DestAddr = dest;
        bus.Mode     = mode;
        bus.Start    = 1'b1;
        @(posedge Clock); #1;
        bus.Start    = 1'b0;
        bus.BaseAddr = 6'($urandom);
        bus.Count    = 7'($urandom_range(1, 64));
        bus.DestAddr = 6'($urandom);
        bus.Mode     = ~mode;
        for (int c = 1; c <= int'(cnt) + 12 && rcyc < 0; c++) begin
            if (bus.ReadEnable) begin
                reads++;
                check({tag, "_rd_addr"}, 32'(bus.Address), 32'((int'(base) + c - 1) % 64));
            end
            if (bus.WriteEnable) begin
                wcyc  = c;
                waddr = bus.Address;
                wdata = bus.DataIN;
            end
            if (bus.Done) begin
                dpulses++;
                if (dcyc < 0) dcyc = c;
            end
            if (bus.Ready && dcyc >= 0) rcyc = c;
            bus.Start = (c == poke);
            @(posedge Clock); #1;
        end
        bus.Start = 1'b0;
        exp_w = (cnt == 0) ? 1 : int'(cnt) + 2;
        check({tag, "_reads"},     32'(reads), 32'(cnt));
        check({tag, "_wr_cycle"},  32'(wcyc), 32'(exp_w));
        check({tag, "_done_cyc"},  32'(dcyc), 32'(exp_w + 1));
        check({tag, "_ready_cyc"}, 32'(rcyc), 32'(exp_w + 2));
        check({tag, "_done_cnt"},  32'(dpulses), 32'd1);
        check({tag, "_wr_addr"},   32'(waddr), 32'(dest));
        check({tag, "_wr_data"},   32'(wdata), 32'(exp_sum));
        check({tag, "_mem_dest"},  32'(mem[dest]), 32'(exp_sum));
        check({tag, "_ovf"},       32'(bus.Overflow), 32'(exp_ovf));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        Reset        = 1'b0;
        bus.Start    = 1'b0;
        bus.BaseAddr = '0;
        bus.Count    = '0;
        bus.DestAddr = '0;
        bus.Mode     = 1'b0;
        bus.DataOut  = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("idle_ready", 32'(bus.Ready), 32'd1);

        // Plain four-word sum
        mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
        run("basic", 6'd0, 7'd4, 6'd10, 1'b0, 16'd10, 1'b0, 0);

        // Source range wraps past the top of memory
        mem[62] = 16'd5; mem[63] = 16'd6; mem[0] = 16'd7;
        run("wrap_addr", 6'd62, 7'd3, 6'd20, 1'b0, 16'd18, 1'b0, 0);

        // Carry out: wrap then saturate, then a clean run clears the flag
        mem[0] = 16'hFFFF; mem[1] = 16'h0002;
        run("ovf_wrap", 6'd0, 7'd2, 6'd30, 1'b0, 16'h0001, 1'b1, 0);
        run("ovf_sat",  6'd0, 7'd2, 6'd31, 1'b1, 16'hFFFF, 1'b1, 0);
        run("ovf_clr",  6'd2, 7'd2, 6'd32, 1'b0, 16'd7, 1'b0, 0);

        // Zero-length run writes zero without any read
        mem[5] = 16'h1234;
        run("count0", 6'd0, 7'd0, 6'd5, 1'b0, 16'h0000, 1'b0, 0);

        // Reset in the middle of a fetch
        for (int i = 0; i < 8; i++) mem[8 + i] = 16'h0100 + 16'(i);
        mem[40] = 16'hAAAA;
        @(negedge Clock);
        bus.BaseAddr = 6'd8; bus.Count = 7'd8; bus.DestAddr = 6'd40; bus.Mode = 1'b0;
        bus.Start = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("midrun_state", 32'(dbg_state), 32'd1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge Clock);
        Reset = 1'b1;
        repeat (12) @(posedge Clock);
        #1;
        check("midrun_no_write", 32'(mem[40]), 32'h0000AAAA);
        run("after_rst", 6'd8, 7'd8, 6'd40, 1'b0, 16'h081C, 1'b0, 0);

        // Start raised during WRITE is ignored
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        run("start_in_wr", 6'd2, 7'd2, 6'd50, 1'b0, 16'd7, 1'b0, 4);
        for (int k = 0; k < 4; k++) begin
            check("post_poke_ready", 32'(bus.Ready), 32'd1);
            check("post_poke_re",    32'(bus.ReadEnable), 32'd0);
            @(posedge Clock); #1;
        end
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < 64; i++)
                if (i != 50 && mem[i] !== snap[i]) diffs++;
            check("poke_mem_untouched", 32'(diffs), 32'd0);
        end

        // Every location once, destination inside the source range
        for (int i = 0; i < 64; i++) mem[i] = 16'(i + 1);
        run("full", 6'd17, 7'd64, 6'd3, 1'b0, 16'd2080, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
